// File: rtl/terrain_crater_ctrl_if.sv
// terrain_crater_ctrl_if
//   Bundles the crater sequencer's impact request, status, renderer-arbitration
//   and terrain SRAM signals.
//   slave  : the crater controller
//   master : game logic / renderer / SRAM side
//   Signals: terrain_ready, start, cx, cy, radius (impact request)
//            busy, done (status)
//            vid_active, vid_read_addr (renderer read request)
//            mem_read_addr, mem_q (shared SRAM read port, 1-cycle latency)
//            mem_we, mem_write_addr, mem_data (SRAM write port)
interface terrain_crater_ctrl_if #(
    parameter int RW = 6
);
    logic          terrain_ready;
    logic          start;
    logic [9:0]    cx;
    logic [9:0]    cy;
    logic [RW-1:0] radius;
    logic          busy;
    logic          done;
    logic          vid_active;
    logic [9:0]    vid_read_addr;
    logic [9:0]    mem_read_addr;
    logic [511:0]  mem_q;
    logic          mem_we;
    logic [9:0]    mem_write_addr;
    logic [511:0]  mem_data;

    modport slave (
        input  terrain_ready, start, cx, cy, radius,
        input  vid_active, vid_read_addr, mem_q,
        output busy, done, mem_read_addr, mem_we, mem_write_addr, mem_data
    );

    modport master (
        output terrain_ready, start, cx, cy, radius,
        output vid_active, vid_read_addr, mem_q,
        input  busy, done, mem_read_addr, mem_we, mem_write_addr, mem_data
    );
endinterface

// File: rtl/terrain_crater_ctrl.sv
// terrain_crater_ctrl
//   Carves a circular crater into column-organised terrain memory (one 512-bit
//   word per column, bit = row, 1 = ground) with one read-modify-write per
//   column, walking columns in ascending order. The SRAM read port is shared
//   with the renderer, which always wins.
//   Ports: clk, reset (sync, active low), bus (terrain_crater_ctrl_if.slave).
module terrain_crater_ctrl #(
    parameter int NCOLS = 640,
    parameter int NROWS = 480,
    parameter int RW    = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    terrain_crater_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, SQRT, READ, WAIT, WRITE, NEXT, DONE} state_t;

    state_t         state, state_nxt;
    logic [9:0]     x, x1, cx_r, cy_r;
    logic [RW-1:0]  r_r, h;
    logic           mem_we_r;
    logic [9:0]     mem_write_addr_r;
    logic [511:0]   mem_data_r;

    // Column range at acceptance. Only cx < NCOLS reaches SQRT, so the
    // unsigned forms below match the signed clamp exactly.
    logic [10:0]    hi_sum;
    logic [9:0]     x0_start, x1_start;
    logic           accept, cx_valid;

    assign accept   = bus.start && bus.terrain_ready;
    assign cx_valid = bus.cx < 10'(NCOLS);
    assign hi_sum   = {1'b0, bus.cx} + 11'(bus.radius);
    assign x0_start = (bus.cx >= 10'(bus.radius)) ? bus.cx - 10'(bus.radius) : '0;
    assign x1_start = (hi_sum > 11'(NCOLS - 1)) ? 10'(NCOLS - 1) : hi_sum[9:0];

    // Half-height search: largest h <= r with h^2 + dx^2 <= r^2.
    logic [9:0]     dx10;
    logic [12:0]    dx13, h13, r13, hh, dd, rr;
    logic           fits;

    assign dx10 = (x >= cx_r) ? x - cx_r : cx_r - x;
    assign dx13 = 13'(dx10);
    assign h13  = 13'(h);
    assign r13  = 13'(r_r);
    assign hh   = h13 * h13;
    assign dd   = dx13 * dx13;
    assign rr   = r13 * r13;
    assign fits = (hh + dd) <= rr;

    // Rows cy-h..cy+h cleared, never touching rows >= NROWS.
    logic [511:0]   clr;
    int             lo_i, hi_i;

    always_comb begin
        clr  = '0;
        lo_i = int'(cy_r) - int'(h);
        hi_i = int'(cy_r) + int'(h);
        for (int i = 0; i < 512; i++) begin
            if (i >= lo_i && i <= hi_i && i < NROWS)
                clr[i] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = cx_valid ? SQRT : DONE;
            SQRT:    if (fits) state_nxt = READ;
                     else if (h == '0) state_nxt = NEXT;
            READ:    if (!bus.vid_active) state_nxt = WAIT;
            WAIT:    state_nxt = WRITE;
            WRITE:   state_nxt = NEXT;
            NEXT:    state_nxt = (x == x1) ? DONE : SQRT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            x                <= '0;
            x1               <= '0;
            cx_r             <= '0;
            cy_r             <= '0;
            r_r              <= '0;
            h                <= '0;
            mem_we_r         <= 1'b0;
            mem_write_addr_r <= '0;
            mem_data_r       <= '0;
        end else begin
            state    <= state_nxt;
            mem_we_r <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    cx_r <= bus.cx;
                    cy_r <= bus.cy;
                    r_r  <= bus.radius;
                    h    <= bus.radius;
                    x    <= x0_start;
                    x1   <= x1_start;
                end
                SQRT: if (!fits && h != '0) h <= h - 1'b1;
                // mem_q holds the column read issued in READ; the modified
                // word is registered so the write lands during WRITE.
                WAIT: begin
                    mem_we_r         <= 1'b1;
                    mem_write_addr_r <= x;
                    mem_data_r       <= bus.mem_q & ~clr;
                end
                NEXT: if (x != x1) begin
                    x <= x + 1'b1;
                    h <= r_r;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy           = (state != IDLE);
    assign bus.done           = (state == DONE);
    assign bus.mem_read_addr  = (bus.vid_active || state != READ) ? bus.vid_read_addr : x;
    assign bus.mem_we         = mem_we_r;
    assign bus.mem_write_addr = mem_write_addr_r;
    assign bus.mem_data       = mem_data_r;
endmodule

// File: tb/tb_terrain_crater_ctrl.sv
module tb_terrain_crater_ctrl;
    typedef struct {
        logic [9:0]   addr;
        logic [511:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    terrain_crater_ctrl_if #(.RW(6)) bus();
    terrain_crater_ctrl #(.NCOLS(640), .NROWS(480), .RW(6)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int vectors = 0;
    int errs    = 0;
    int wr_cnt  = 0;
    int done_cnt = 0;
    wr_t sb[$];

    // SRAM model: registered read, one-cycle latency. Column index is XORed
    // into rows 0..9 so a read from the wrong column yields different data.
    logic [511:0] mem [0:1023];
    logic [511:0] ref_mem [0:1023];
    logic         load = 1'b0;
    logic [511:0] load_word = '0;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 1024; i++) mem[i] <= load_word ^ 512'(i);
        end else begin
            bus.mem_q <= mem[bus.mem_read_addr];
            if (bus.mem_we) mem[bus.mem_write_addr] <= bus.mem_data;
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: each write must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (bus.mem_we) begin
            wr_cnt++;
            chk("write_expected", 512'(sb.size() > 0), 512'(1));
            if (sb.size() > 0) begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", 512'(bus.mem_write_addr), 512'(e.addr));
                chk("wr_data", bus.mem_data, e.data);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic preload(input logic [511:0] w);
        for (int i = 0; i < 1024; i++) ref_mem[i] = w ^ 512'(i);
        load_word = w;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Reference crater: per column, h = floor(sqrt(r^2 - dx^2)).
    function automatic void push_crater(input int cx, input int cy, input int r);
        int lo, hi;
        if (cx >= 640) return;
        lo = (cx - r < 0) ? 0 : cx - r;
        hi = (cx + r > 639) ? 639 : cx + r;
        for (int x = lo; x <= hi; x++) begin
            int dx;
            int h;
            logic [511:0] w;
            dx = (x > cx) ? x - cx : cx - x;
            h = r;
            while (h * h + dx * dx > r * r) h--;
            w = ref_mem[x];
            for (int i = cy - h; i <= cy + h; i++)
                if (i >= 0 && i < 480) w[i] = 1'b0;
            ref_mem[x] = w;
            sb.push_back('{addr: 10'(x), data: w});
        end
    endfunction

    task automatic fire(input int cx, input int cy, input int r);
        bus.cx = 10'(cx);
        bus.cy = 10'(cy);
        bus.radius = 6'(r);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < lim && !seen; k++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk(tag, 512'(seen), 512'(1));
        tick();
        @(negedge clk);
        chk({tag, "_busy_low"}, 512'(bus.busy), 512'(0));
        tick();
    endtask

    logic [511:0] ones = '1;
    logic [511:0] ground;
    int base_wr, base_done, own_wr;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ground = ones << 330;
        reset = 1'b0;
        bus.terrain_ready = 1'b1;
        bus.start = 1'b1;
        bus.cx = 10'd100; bus.cy = 10'd330; bus.radius = 6'd4;
        bus.vid_active = 1'b0;
        bus.vid_read_addr = 10'd5;

        // Reset held with start asserted
        repeat (3) begin
            @(negedge clk);
            chk("rst_busy", 512'(bus.busy), 512'(0));
            chk("rst_done", 512'(bus.done), 512'(0));
            chk("rst_we",   512'(bus.mem_we), 512'(0));
        end
        tick();
        reset = 1'b1;
        bus.terrain_ready = 1'b0;
        tick(2);
        bus.start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("not_ready_busy", 512'(bus.busy), 512'(0));
        end
        tick();
        chk("not_ready_writes", 512'(wr_cnt), 512'(0));
        bus.terrain_ready = 1'b1;

        // Basic crater
        preload(ground);
        base_wr = wr_cnt;
        push_crater(100, 330, 4);
        fire(100, 330, 4);
        wait_done("basic_done", 300);
        chk("basic_count", 512'(wr_cnt - base_wr), 512'(9));
        chk("basic_sb_empty", 512'(sb.size()), 512'(0));
        chk("basic_col100", 512'(mem[100][335:320]), 512'(16'h8000));
        chk("basic_col96",  512'(mem[96][333:328]), 512'(6'b111000));

        // Edge clipping at column 0 and bottom rows
        preload(ones);
        base_wr = wr_cnt;
        push_crater(2, 477, 5);
        fire(2, 477, 5);
        wait_done("edge_done", 300);
        chk("edge_count", 512'(wr_cnt - base_wr), 512'(8));
        chk("edge_hi_rows", 512'(mem[2][511:480]), 512'(32'hFFFF_FFFF));
        chk("edge_col2", 512'(mem[2][479:470]), 512'(10'b0000000011));

        base_wr = wr_cnt;
        fire(700, 10, 3);
        wait_done("offscreen_done", 20);
        chk("offscreen_count", 512'(wr_cnt - base_wr), 512'(0));

        // Renderer priority
        preload(ground);
        base_wr = wr_cnt;
        push_crater(300, 330, 4);
        fire(300, 330, 4);
        bus.vid_active = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.vid_read_addr = 10'(700 + k);
            if (k == 10) own_wr = wr_cnt;
            @(negedge clk);
            chk("vid_addr", 512'(bus.mem_read_addr), 512'(700 + k));
            tick();
        end
        chk("vid_stall", 512'(wr_cnt - own_wr), 512'(0));
        bus.vid_active = 1'b0;
        bus.vid_read_addr = 10'd5;
        wait_done("vid_done", 300);
        chk("vid_count", 512'(wr_cnt - base_wr), 512'(9));

        // Second start while busy is dropped
        preload(ground);
        base_wr = wr_cnt;
        base_done = done_cnt;
        push_crater(200, 330, 3);
        fire(200, 330, 3);
        tick(3);
        fire(400, 300, 3);
        wait_done("busy_done", 300);
        tick(30);
        chk("busy_done_cnt", 512'(done_cnt - base_done), 512'(1));
        chk("busy_count", 512'(wr_cnt - base_wr), 512'(7));

        // Reset after the third write
        preload(ground);
        base_wr = wr_cnt;
        push_crater(500, 330, 4);
        fire(500, 330, 4);
        own_wr = 0;
        for (int k = 0; k < 300 && own_wr < 3; k++) begin
            @(negedge clk);
            if (bus.mem_we) own_wr++;
        end
        chk("midrst_reached3", 512'(own_wr), 512'(3));
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        sb.delete();
        repeat (15) begin
            @(negedge clk);
            chk("midrst_we", 512'(bus.mem_we), 512'(0));
            chk("midrst_busy", 512'(bus.busy), 512'(0));
        end
        tick();
        chk("midrst_count", 512'(wr_cnt - base_wr), 512'(3));

        preload(ground);
        base_wr = wr_cnt;
        push_crater(50, 330, 2);
        fire(50, 330, 2);
        wait_done("fresh_done", 300);
        chk("fresh_count", 512'(wr_cnt - base_wr), 512'(5));
        chk("fresh_sb_empty", 512'(sb.size()), 512'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
